// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin sequencer of set/reset pulses onto an SR latch bank.
// Define SR_LATCH_CTRL_VERIFY_EN to build the q readback compare that drives err.
module sr_latch_ctrl #(
  parameter int N         = 4,
  parameter int IDXW      = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [IDXW-1:0] a_idx,
  input  logic            a_op,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [IDXW-1:0] b_idx,
  input  logic            b_op,
  output logic [N-1:0]    s_out,
  output logic [N-1:0]    r_out,
  input  logic [N-1:0]    q_in,
  output logic            busy,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic prio_q, prio_d;
  logic err_q, err_d;
  logic grant_a, grant_b;
  // prio_q = 1 means B wins a tie
  assign grant_a = a_valid && (!b_valid || !prio_q);
  assign grant_b = b_valid && (!a_valid || prio_q);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    err_d   = err_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    s_out   = '0;
    r_out   = '0;
    case (state_q)
      IDLE: begin
        a_ready = rst_n && grant_a;
        b_ready = rst_n && grant_b;
        if (a_ready || b_ready) begin
          idx_d   = a_ready ? a_idx : b_idx;
          op_d    = a_ready ? a_op : b_op;
          cnt_d   = 4'(PULSE_CYC - 1);
          prio_d  = a_ready;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        s_out[idx_q] = op_q;
        r_out[idx_q] = !op_q;
        cnt_d        = cnt_q - 4'd1;
        state_d      = (cnt_q == 4'd0) ? RELEASE : DRIVE;
      end
      RELEASE: begin
        state_d = IDLE;
`ifdef SR_LATCH_CTRL_VERIFY_EN
        err_d = err_q || (q_in[idx_q] != op_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end
  assign busy = (state_q != IDLE);
`ifdef SR_LATCH_CTRL_VERIFY_EN
  assign err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^{q_in, err_q, err_d};
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed checks of arbitration, pulse timing, reset and readback error.
module tb_sr_latch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, b_ready;
  logic [1:0] a_idx = '0, b_idx = '0;
  logic a_op = 1'b0, b_op = 1'b0;
  logic [3:0] s_out, r_out, q_in;
  logic busy, err;
  logic [3:0] q_model = '0;
  logic [3:0] force_zero = '0;
  int errors = 0;
  int checks = 0;
`ifdef SR_LATCH_CTRL_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  sr_latch_ctrl #(.N(4), .IDXW(2), .PULSE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_op(b_op),
    .s_out(s_out), .r_out(r_out), .q_in(q_in), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // behavioural latch bank fed by the controller drives
  always @(posedge clk) q_model <= (q_model | s_out) & ~r_out;
  assign q_in = q_model & ~force_zero;

  always @(negedge clk) begin
    checks++;
    if (((s_out & r_out) !== 4'b0) || ($countones(s_out | r_out) > 1)) begin
      errors++;
      $display("FAIL drive_excl: s_out=%b r_out=%b required disjoint one-hot-or-zero", s_out, r_out);
    end
  end

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    cyc();
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready}); end
    checks++;
    if ({s_out, r_out} !== 8'h00) begin errors++; $display("FAIL reset_drive: got %h required 00", {s_out, r_out}); end
    checks++;
    if ({busy, err} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b required 00", {busy, err}); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single;
    a_valid = 1'b1; a_idx = 2'd2; a_op = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready, busy} !== 3'b100) begin errors++; $display("FAIL single_accept: ready/busy got %b required 100", {a_ready, b_ready, busy}); end
    cyc();
    a_valid = 1'b0;
    #1;
    checks++;
    if ({s_out, r_out, busy, a_ready} !== {4'b0100, 4'b0000, 1'b1, 1'b0}) begin errors++; $display("FAIL single_t1: s=%b r=%b busy=%b rdy=%b required s=0100 r=0000 busy=1 rdy=0", s_out, r_out, busy, a_ready); end
    cyc();
    checks++;
    if ({s_out, r_out} !== {4'b0100, 4'b0000}) begin errors++; $display("FAIL single_t2: s=%b r=%b required s=0100 r=0000", s_out, r_out); end
    cyc();
    checks++;
    if ({s_out, r_out, busy} !== {8'h00, 1'b1}) begin errors++; $display("FAIL single_release: s=%b r=%b busy=%b required 0000 0000 1", s_out, r_out, busy); end
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b required 0", busy); end
    checks++;
    if (q_model[2] !== 1'b1) begin errors++; $display("FAIL single_q: q[2]=%b required 1", q_model[2]); end
  endtask

  task automatic test_alternate;
    int n;
    logic [1:0] want;
    do_reset();
    a_valid = 1'b1; a_idx = 2'd0; a_op = 1'b1;
    b_valid = 1'b1; b_idx = 2'd0; b_op = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!(a_ready || b_ready) && n < 12) begin cyc(); n++; end
      want = (g == 1) ? 2'b01 : 2'b10;
      checks++;
      if ({a_ready, b_ready} !== want) begin errors++; $display("FAIL alt_grant%0d: ready a/b got %b required %b", g, {a_ready, b_ready}, want); end
      if (g > 0) begin
        checks++;
        if (n !== 3) begin errors++; $display("FAIL alt_gap%0d: waited %0d cycles required 3", g, n); end
      end
      cyc();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (q_model[0] !== 1'b1) begin errors++; $display("FAIL alt_final_q: q[0]=%b required 1", q_model[0]); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL alt_err: err=%b required 0", err); end
  endtask

  task automatic test_b_alone;
    do_reset();
    a_valid = 1'b1; a_idx = 2'd1; a_op = 1'b1;
    cyc();
    a_valid = 1'b0;
    b_valid = 1'b1; b_idx = 2'd3; b_op = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (b_ready !== 1'b0) begin errors++; $display("FAIL b_wait%0d: b_ready=%b required 0", i, b_ready); end
      cyc();
    end
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL b_grant: ready a/b got %b required 01", {a_ready, b_ready}); end
    cyc();
    checks++;
    if ({b_ready, s_out} !== {1'b0, 4'b1000}) begin errors++; $display("FAIL b_pulse: b_ready=%b s=%b required 0 1000", b_ready, s_out); end
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic test_reset_mid;
    do_reset();
    a_valid = 1'b1; a_idx = 2'd1; a_op = 1'b0;
    cyc();
    a_valid = 1'b0;
    #1;
    checks++;
    if (r_out !== 4'b0010) begin errors++; $display("FAIL mid_drive: r=%b required 0010", r_out); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_out, r_out, busy} !== 9'h0) begin errors++; $display("FAIL mid_async: s=%b r=%b busy=%b required all 0", s_out, r_out, busy); end
    cyc();
    rst_n = 1'b1;
    cyc();
    a_valid = 1'b1; a_idx = 2'd1; a_op = 1'b1;
    b_valid = 1'b1; b_idx = 2'd2; b_op = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL mid_prio: ready a/b got %b required 10", {a_ready, b_ready}); end
    cyc();
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
  endtask

  task automatic test_verify;
    do_reset();
    force_zero = 4'b0010;
    a_valid = 1'b1; a_idx = 2'd1; a_op = 1'b1;
    cyc();
    a_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL verify_release: err=%b required 0", err); end
    cyc();
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL verify_set: err=%b required %b", err, VERIFY); end
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL verify_sticky: err=%b required %b", err, VERIFY); end
    force_zero = '0;
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL verify_clear: err=%b required 0", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_b_alone();
    test_reset_mid();
    test_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Sequencing controller for a bank of SR latches. It accepts set/reset commands from two requesters over valid/ready handshakes and arbitrates between them round-robin. Each granted command becomes a fixed-width pulse on exactly one latch's s or r input, followed by a release cycle. The block guarantees the forbidden s=r=1 condition is never driven onto any latch, and sits between control logic and the latch bank.

## Interface
- N, 4: number of latches in the bank; must be a power of two, ≥2
- IDXW, 2: latch index width; must equal log2(N)
- PULSE_CYC, 2: cycles s or r is held high per command; range 1–15

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_valid  input  1  requester A command valid
- a_ready  output  1  requester A command accepted this cycle
- a_idx  input  IDXW  requester A target latch
- a_op  input  1  requester A operation: 1 = set, 0 = reset
- b_valid  input  1  requester B command valid
- b_ready  output  1  requester B command accepted this cycle
- b_idx  input  IDXW  requester B target latch
- b_op  input  1  requester B operation: 1 = set, 0 = reset
- s_out  output  N  per-latch set drive
- r_out  output  N  per-latch reset drive
- q_in  input  N  latch q readback
- busy  output  1  high whenever the FSM is not IDLE
- err  output  1  sticky readback-mismatch flag (see Configuration)

## Operation
- FSM states are IDLE, DRIVE and RELEASE.
- **IDLE**
  - s_out = r_out = 0.
  - The arbiter evaluates a_valid and b_valid.
  - If only one is valid, that requester is granted.
  - If both are valid, the requester holding priority is granted.
  - The granted ready is asserted combinationally in the same cycle. The other ready stays 0.
  - On acceptance:
    - latch idx/op into internal registers;
    - load the pulse counter with PULSE_CYC−1;
    - move priority to the other requester;
    - go to DRIVE.
- **DRIVE**
  - Only bit idx is driven, and only one of the two signals:
    - op = 1: s_out[idx] = 1;
    - op = 0: r_out[idx] = 1;
    - every other s_out/r_out bit is 0.
  - The counter decrements each cycle. When it reaches 0, go to RELEASE.
- **RELEASE**
  - s_out = r_out = 0 for one cycle, then go to IDLE.
- a_ready and b_ready are 0 in DRIVE and RELEASE.
- Requesters must hold valid, idx and op stable until ready is seen.
- s_out & r_out == 0 on every bit and in every cycle, including reset.
- Conflicting commands to the same index from both requesters are serialized in grant order. The last executed command determines the final q.
- Redundant commands (e.g. set on a latch already at q = 1) are executed normally.

## Timing
- Acceptance in cycle T drives the pulse during T+1 … T+PULSE_CYC.
- The release cycle is T+PULSE_CYC+1.
- The earliest next acceptance is T+PULSE_CYC+2. Back-to-back throughput is one command per PULSE_CYC+2 cycles.
- Reset values:
  - s_out = 0, r_out = 0;
  - a_ready = b_ready = 0 while rst_n is low;
  - busy = 0, err = 0;
  - FSM in IDLE, priority on A.
- Reset mid-operation: all drives drop to 0 immediately (asynchronously). The in-flight command is abandoned, with no completion and no error.
- Valid deasserted while the FSM is busy: no effect; the command is not queued.
- Both requesters valid continuously: grants alternate A, B, A, B…

## Configuration
- `SR_LATCH_CTRL_VERIFY_EN` **defined:**
  - In RELEASE, compare q_in[idx] with op.
  - On a mismatch, err is set on the next clock edge.
  - err is sticky until rst_n is asserted.
- `SR_LATCH_CTRL_VERIFY_EN` **undefined:** no compare logic is built; err is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then a_valid=1, a_idx=2, a_op=1 → a_ready=1 at T; s_out=4'b0100 during T+1..T+2 (PULSE_CYC=2); all drives 0 at T+3; busy=0 at T+4.
- a_valid and b_valid both high continuously, with A idx0 set and B idx0 reset → grants alternate A, B, A; s_out[0] and r_out[0] are never high together; the final q matches the last grant.
- b_valid alone after an A grant → B granted at the first IDLE cycle; b_ready is a single-cycle pulse.
- rst_n pulled low during DRIVE → s_out and r_out are 0 in the same cycle; after release, the first request is granted to A when both are valid.
- VERIFY_EN build: q_in forced to 0 during a set command on idx1 → err=1 from T+PULSE_CYC+2 and stays high until reset. Non-VERIFY build with the same stimulus → err stays 0.
- Every cycle of every test: assert (s_out & r_out)==0 and popcount(s_out|r_out) ≤ 1.
